conv1_sched: RTL and testbench

- Sequencer that time-multiplexes a single-output-channel slice of the first binary conv layer: 5 kernels XOR-convolved, accumulated, offset-binarised into one 24x24 map.
- For each of 18 output channels it fetches the 5 binary 5x5 kernels and one offset from weight memories, starts the shared datapath, waits for completion, then hands the result downstream via valid/ready.
- Sits between the weight store and the conv1 channel datapath; top-level control issues start and observes done.

---
 rtl/conv1_pkg.sv | 37 +++
 rtl/conv1_kern_latch.sv | 47 ++++
 rtl/conv1_sched.sv | 155 +++++++++++++++
 tb/tb_conv1_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv1_pkg.sv
// Shared constants, types and helpers for the conv1 channel scheduler.
package conv1_pkg;

    localparam int N_CH     = 18;   // output channels sequenced per frame
    localparam int K_PER_CH = 5;    // kernels accumulated per output channel
    localparam int KW       = 25;   // bits per flattened 5x5 binary kernel
    localparam int bW       = 8;    // kernel offset width
    localparam int AW       = 7;    // kernel memory address width
    localparam int CW       = 5;    // channel index width
    localparam int SW       = 3;    // kernel slot index width
    localparam int IMG      = 28;   // input image side
    localparam int OMAP     = 24;   // output map side

    localparam logic [CW-1:0] CH_LAST = CW'(N_CH - 1);
    localparam logic [SW-1:0] K_LAST  = SW'(K_PER_CH - 1);

    typedef logic [KW-1:0] kernel_t;
    typedef logic [bW-1:0] offset_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LATCH   = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_EMIT    = 3'd4,
        ST_FIN     = 3'd5
    } sched_state_t;

    // Flat kernel memory index of kernel k belonging to channel ch.
    function automatic logic [AW-1:0] kern_index(input logic [CW-1:0] ch,
                                                 input logic [SW-1:0] k);
        logic [AW-1:0] idx;
        idx = AW'(ch) * AW'(K_PER_CH) + AW'(k);
        return idx;
    endfunction

endpackage

// File: rtl/conv1_kern_latch.sv
// Kernel slot register file plus offset register feeding the conv1 datapath.
module conv1_kern_latch
    import conv1_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     kern_we_i,
    input  logic [SW-1:0]            kern_slot_i,
    input  kernel_t                  kern_data_i,
    input  logic                     off_we_i,
    input  offset_t                  off_data_i,
    output logic [K_PER_CH*KW-1:0]   kern_bus_o,
    output offset_t                  off_o
);

    kernel_t slot_q [K_PER_CH];
    offset_t off_q;

    // Slot-addressed kernel writes and offset capture; contents survive abort.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < K_PER_CH; i++) begin
                slot_q[i] <= {KW{1'b0}};
            end
            off_q <= {bW{1'b0}};
        end else begin
            for (int i = 0; i < K_PER_CH; i++) begin
                if (kern_we_i && (kern_slot_i == SW'(i))) begin
                    slot_q[i] <= kern_data_i;
                end
            end
            if (off_we_i) begin
                off_q <= off_data_i;
            end
        end
    end

    // Pack the slots onto the flat kernel bus, slot k at bits [k*KW +: KW].
    always_comb begin
        kern_bus_o = {(K_PER_CH*KW){1'b0}};
        for (int i = 0; i < K_PER_CH; i++) begin
            kern_bus_o[i*KW +: KW] = slot_q[i];
        end
        off_o = off_q;
    end

endmodule

// File: rtl/conv1_sched.sv
// Per-frame sequencer: fetch 5 kernels + offset per channel, run the shared
// datapath, then hand each channel result downstream over valid/ready.
module conv1_sched
    import conv1_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     wt_rd_en,
    output logic [AW-1:0]            wt_addr,
    input  kernel_t                  wt_rdata,
    output logic                     off_rd_en,
    output logic [CW-1:0]            off_addr,
    input  offset_t                  off_rdata,
    output logic [K_PER_CH*KW-1:0]   kern_bus,
    output offset_t                  off_out,
    output logic                     dp_start,
    input  logic                     dp_done,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [CW-1:0]            res_chan
);

    sched_state_t  state_q, state_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [SW-1:0] k_q, k_d;
    logic          first_q, first_d;   // marks the first COMPUTE cycle

    logic          kern_we_s;
    logic [SW-1:0] kern_slot_s;
    logic          off_we_s;

    // State, channel and kernel counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ch_q    <= {CW{1'b0}};
            k_q     <= {SW{1'b0}};
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            k_q     <= k_d;
            first_q <= first_d;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        k_d     = k_q;
        first_d = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ch_d    = {CW{1'b0}};
                        k_d     = {SW{1'b0}};
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (k_q == K_LAST) begin
                        k_d     = {SW{1'b0}};
                        state_d = ST_LATCH;
                    end else begin
                        k_d     = k_q + SW'(1);
                    end
                end
                ST_LATCH: begin
                    first_d = 1'b1;
                    state_d = ST_COMPUTE;
                end
                ST_COMPUTE: begin
                    if (dp_done) begin
                        state_d = ST_EMIT;
                    end else begin
                        state_d = ST_COMPUTE;
                    end
                end
                ST_EMIT: begin
                    if (!res_ready) begin
                        state_d = ST_EMIT;
                    end else if (ch_q == CH_LAST) begin
                        state_d = ST_FIN;
                    end else begin
                        ch_d    = ch_q + CW'(1);
                        k_d     = {SW{1'b0}};
                        state_d = ST_FETCH;
                    end
                end
                ST_FIN: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Latch enables: read data lags the strobe by one cycle, so slot k-1 is
    // written while kernel k is requested and slot 4 in LATCH.
    always_comb begin
        kern_we_s   = 1'b0;
        kern_slot_s = {SW{1'b0}};
        off_we_s    = 1'b0;
        if (abort) begin
            kern_we_s = 1'b0;
        end else if ((state_q == ST_FETCH) && (k_q != {SW{1'b0}})) begin
            kern_we_s   = 1'b1;
            kern_slot_s = k_q - SW'(1);
            off_we_s    = (k_q == SW'(1));
        end else if (state_q == ST_LATCH) begin
            kern_we_s   = 1'b1;
            kern_slot_s = K_LAST;
        end else begin
            kern_we_s = 1'b0;
        end
    end

    // Output decode purely from registered state.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_FIN);
        wt_rd_en  = (state_q == ST_FETCH);
        wt_addr   = wt_rd_en ? kern_index(ch_q, k_q) : {AW{1'b0}};
        off_rd_en = (state_q == ST_FETCH) && (k_q == {SW{1'b0}});
        off_addr  = off_rd_en ? ch_q : {CW{1'b0}};
        dp_start  = (state_q == ST_COMPUTE) && first_q;
        res_valid = (state_q == ST_EMIT);
        res_chan  = ch_q;
    end

    conv1_kern_latch u_latch (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .kern_we_i   (kern_we_s),
        .kern_slot_i (kern_slot_s),
        .kern_data_i (wt_rdata),
        .off_we_i    (off_we_s),
        .off_data_i  (off_rdata),
        .kern_bus_o  (kern_bus),
        .off_o       (off_out)
    );

endmodule

// File: tb/tb_conv1_sched.sv
// Self-checking bench for conv1_sched: memory and datapath responders plus a
// transaction-level model (fetch order, per-channel kernels, result order).
module tb_conv1_sched;
    import conv1_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic dp_done = 1'b0;
    logic res_ready = 1'b1;
    kernel_t wt_rdata = {KW{1'b0}};
    offset_t off_rdata = {bW{1'b0}};

    logic busy, done, wt_rd_en, off_rd_en, dp_start, res_valid;
    logic [AW-1:0] wt_addr;
    logic [CW-1:0] off_addr, res_chan;
    logic [K_PER_CH*KW-1:0] kern_bus;
    offset_t off_out;

    conv1_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .wt_rd_en(wt_rd_en), .wt_addr(wt_addr),
        .wt_rdata(wt_rdata), .off_rd_en(off_rd_en), .off_addr(off_addr),
        .off_rdata(off_rdata), .kern_bus(kern_bus), .off_out(off_out),
        .dp_start(dp_start), .dp_done(dp_done), .res_valid(res_valid),
        .res_ready(res_ready), .res_chan(res_chan)
    );

    always #5 clk = ~clk;

    // Memories: wt[i] = i, off[c] = c + 100, one-cycle latency; junk otherwise.
    always @(posedge clk) begin
        wt_rdata  <= wt_rd_en ? KW'(wt_addr) : 25'h1555555;
        off_rdata <= off_rd_en ? bW'(32'(off_addr) + 32'd100) : 8'hEE;
    end

    int n_cmp = 0, n_err = 0, cyc = 0;
    // model state
    int exp_addr = 0, exp_hs = 0, dp_cnt = 0, done_cnt = 0;
    int start_cyc = 0, done_cyc = 0, last_hs_cyc = -100;
    int hs_cyc [N_CH];
    logic [K_PER_CH*KW-1:0] kb4;
    offset_t off4;
    bit prev_valid = 0, prev_hs = 0, prev_abort = 0, prev_busy = 0, prev_done = 0;
    logic [CW-1:0] prev_chan;
    // responder controls
    int dp_lat = 3, resp_cnt = 0, bp_chan = 3, bp_left = 0;
    bit dp_imm = 0, spur_en = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [K_PER_CH*KW-1:0] kb_of(input int c);
        logic [K_PER_CH*KW-1:0] v;
        v = {(K_PER_CH*KW){1'b0}};
        for (int k = 0; k < K_PER_CH; k++) v[k*KW +: KW] = KW'(c*K_PER_CH + k);
        return v;
    endfunction

    task automatic respond();
        if (dp_imm) dp_done = dp_start;
        else begin
            dp_done = 1'b0;
            if (dp_start) resp_cnt = dp_lat;
            else if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) dp_done = 1'b1;
            end
        end
        if (spur_en && (!busy || res_valid)) dp_done = 1'b1;
        if (res_valid && res_chan == CW'(bp_chan) && bp_left > 0) begin
            res_ready = 1'b0;
            bp_left--;
        end else res_ready = 1'b1;
    endtask

    task automatic check();
        bit hs;
        if (!rst_n) begin
            prev_valid = 0; prev_hs = 0; prev_abort = 0; prev_busy = 0; prev_done = 0;
            return;
        end
        if (prev_abort) begin
            chk("abort_busy", busy, 0);
            chk("abort_valid", res_valid, 0);
            chk("abort_rd", wt_rd_en, 0);
        end
        if (busy && !prev_busy) begin
            chk("start_lat", cyc - start_cyc, 1);
            exp_addr = 0; exp_hs = 0; dp_cnt = 0; last_hs_cyc = -100;
        end
        if (wt_rd_en) begin
            chk("wt_addr", wt_addr, exp_addr);
            chk("off_rd_en", off_rd_en, (exp_addr % K_PER_CH) == 0);
            if (off_rd_en) chk("off_addr", off_addr, exp_addr / K_PER_CH);
            if ((exp_addr % K_PER_CH) == 0 && exp_addr > 0)
                chk("fetch_after_hs", cyc, last_hs_cyc + 1);
            exp_addr++;
        end else if (off_rd_en) chk("off_rd_alone", off_rd_en, 0);
        if (dp_start) begin
            chk("dp_fetched", exp_addr, K_PER_CH*(dp_cnt+1));
            chk("kern_bus", kern_bus, kb_of(dp_cnt));
            chk("off_out", off_out, dp_cnt + 100);
            if (dp_cnt == 0) chk("first_dp", cyc - start_cyc, 7);
            if (dp_cnt == 4) begin kb4 = kern_bus; off4 = off_out; end
            dp_cnt++;
        end
        hs = res_valid && res_ready && !abort;
        if (res_valid) begin
            chk("res_chan", res_chan, exp_hs);
            chk("res_order", dp_cnt, exp_hs + 1);
            chk("emit_no_fetch", wt_rd_en, 0);
            if (prev_valid) chk("chan_hold", res_chan, prev_chan);
            if (hs) begin
                if (exp_hs < N_CH) hs_cyc[exp_hs] = cyc;
                last_hs_cyc = cyc;
                exp_hs++;
            end
        end
        if (prev_valid && !res_valid && !prev_hs && !prev_abort) chk("valid_drop", res_valid, 1);
        if (done) begin
            chk("done_all", exp_hs, N_CH);
            chk("done_after_hs", cyc, last_hs_cyc + 1);
            chk("done_pulse", prev_done, 0);
            done_cnt++;
            done_cyc = cyc;
        end
        if (start && !busy && !abort) start_cyc = cyc;
        prev_valid = res_valid; prev_chan = res_chan; prev_hs = hs;
        prev_abort = abort; prev_busy = busy; prev_done = done;
    endtask

    task automatic tick();
        respond();
        check();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_wt_rd_en"}, wt_rd_en, 0);
        chk({tag, "_wt_addr"}, wt_addr, 0);
        chk({tag, "_off_rd_en"}, off_rd_en, 0);
        chk({tag, "_off_addr"}, off_addr, 0);
        chk({tag, "_kern_bus"}, kern_bus, 0);
        chk({tag, "_off_out"}, off_out, 0);
        chk({tag, "_dp_start"}, dp_start, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_chan"}, res_chan, 0);
    endtask

    task automatic run_frame(input int limit, input int spur_at);
        int d0;
        bit ok;
        d0 = done_cnt;
        ok = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < limit; i++) begin
            start = (i == spur_at);
            tick();
            if (done_cnt != d0) begin ok = 1; break; end
        end
        start = 1'b0;
        chk("frame_done_seen", ok, 1);
        chk("frame_one_done", done_cnt - d0, ok ? 1 : 0);
        tick();
        chk("frame_idle", busy, 0);
    endtask

    initial begin
        logic [K_PER_CH*KW-1:0] lit4;
        int d0;
        lit4 = {25'd24, 25'd23, 25'd22, 25'd21, 25'd20};

        // reset state
        tick(); tick();
        chk_zero("rst");
        rst_n = 1'b1;
        tick(); tick();
        chk("post_rst_idle", busy, 0);

        // nominal frame, dp_done 3 cycles after dp_start, spurious start mid-frame
        run_frame(400, 40);
        chk("A_len", done_cyc - start_cyc, 199);
        chk("A_kb4", kb4, lit4);
        chk("A_off4", off4, 104);
        chk("A_hs", exp_hs, 18);

        // back-pressure on channel 3, spurious dp_done in IDLE and EMIT
        spur_en = 1; bp_left = 10;
        tick(); tick(); tick();
        chk("B_idle_spur", busy, 0);
        run_frame(400, -1);
        spur_en = 0;
        chk("B_len", done_cyc - start_cyc, 209);
        chk("B_gap3", hs_cyc[3] - hs_cyc[2], 21);
        chk("B_gap4", hs_cyc[4] - hs_cyc[3], 11);

        // immediate dp_done: 8-cycle channel period
        dp_imm = 1;
        run_frame(300, -1);
        chk("C_len", done_cyc - start_cyc, 145);
        chk("C_first_hs", hs_cyc[0] - start_cyc, 8);
        for (int c = 0; c < N_CH-1; c++) chk("C_period", hs_cyc[c+1] - hs_cyc[c], 8);
        dp_imm = 0;

        // abort mid-COMPUTE on channel 9
        d0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (dp_cnt == 10) break;
        end
        chk("D_reach9", dp_cnt, 10);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("D_busy", busy, 0);
        chk("D_valid", res_valid, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("D_nodone", done_cnt, d0);
        chk("D_kern_keep", kern_bus, kb_of(9));
        chk("D_off_keep", off_out, 109);
        run_frame(400, -1);
        chk("E_len", done_cyc - start_cyc, 199);

        // async reset during FETCH k=2
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (wt_rd_en && wt_addr == AW'(2)) break;
            tick();
        end
        chk("F_at_k2", wt_addr, 2);
        #2 rst_n = 1'b0;
        #1 chk_zero("F");
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("F_idle", busy, 0);
        dp_imm = 1;
        run_frame(300, -1);
        chk("F_len", done_cyc - start_cyc, 145);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
